// File: rtl/sha512_msg_padder_if.sv
// Message-word stream between upstream producer, SHA-512 padder and the core.
// The padder takes the slave view; the producer/core side takes the master view.
interface sha512_msg_padder_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic        new_msg;
    logic [63:0] msg_word;
    logic        msg_word_valid;
    logic        msg_word_ack;
    logic        msg_complete;

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, msg_word_ack,
        output in_ready, new_msg, msg_word, msg_word_valid, msg_complete
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, msg_word_ack,
        input  in_ready, new_msg, msg_word, msg_word_valid, msg_complete
    );
endinterface

// File: rtl/sha512_msg_padder.sv
// Streaming FIPS 180-4 SHA-512 padder: emits message, 0x80, zero fill and the
// 128-bit bit length as 16 x 64-bit words per block through one output register.
module sha512_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    sha512_msg_padder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, DATA, PAD80, ZERO, LEN_HI, LEN_LO, DONE
    } state_t;

    state_t           state_q;
    logic [63:0]      word_q;
    logic             valid_q;
    logic             new_msg_q;
    logic             complete_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [3:0]       idx_q;

    logic             xfer;
    logic             advance;
    logic             in_phase;
    logic             accept;
    logic             msg_start;
    logic [3:0]       pos;
    logic [3:0]       add_bytes;
    logic [LEN_W-1:0] cnt_base;
    logic [LEN_W-1:0] byte_cnt_d;
    logic [63:0]      last_word_d;
    logic [127:0]     len_bits;

    assign xfer      = valid_q && bus.msg_word_ack;
    assign advance   = !valid_q || bus.msg_word_ack;
    assign in_phase  = (state_q == IDLE) || (state_q == DATA) || (state_q == DONE);
    assign msg_start = (state_q == IDLE) || (state_q == DONE);
    assign accept    = bus.in_valid && in_phase && advance;

    // Block position of the word loaded into the output register this cycle.
    assign pos        = msg_start ? '0 : idx_q + 4'(xfer);
    assign add_bytes  = (bus.in_last && (bus.in_bytes != 3'd0)) ? {1'b0, bus.in_bytes} : 4'd8;
    assign cnt_base   = msg_start ? '0 : byte_cnt_q;
    assign byte_cnt_d = cnt_base + LEN_W'(add_bytes);
    assign len_bits   = 128'(byte_cnt_q) << 3;

    always_comb begin
        last_word_d = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < 32'(bus.in_bytes)) begin
                last_word_d[63-8*b -: 8] = bus.in_data[63-8*b -: 8];
            end else if (b == 32'(bus.in_bytes)) begin
                last_word_d[63-8*b -: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            valid_q    <= 1'b0;
            new_msg_q  <= 1'b0;
            complete_q <= 1'b0;
            byte_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            new_msg_q <= 1'b0;
            if (xfer) begin
                idx_q <= idx_q + 4'd1;
            end
            case (state_q)
                IDLE, DATA, DONE: begin
                    if (accept) begin
                        valid_q    <= 1'b1;
                        byte_cnt_q <= byte_cnt_d;
                        if (msg_start) begin
                            idx_q      <= '0;
                            new_msg_q  <= 1'b1;
                            complete_q <= 1'b0;
                        end
                        if (!bus.in_last) begin
                            word_q  <= bus.in_data;
                            state_q <= DATA;
                        end else if (bus.in_bytes == 3'd0) begin
                            word_q  <= bus.in_data;
                            state_q <= PAD80;
                        end else begin
                            // 0x80 already folded in; go to length if it sits at idx 13
                            word_q  <= last_word_d;
                            state_q <= (pos == 4'd13) ? LEN_HI : ZERO;
                        end
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                    end
                end
                PAD80, ZERO: begin
                    if (advance) begin
                        word_q  <= (state_q == PAD80) ? 64'h8000_0000_0000_0000 : '0;
                        state_q <= (pos == 4'd13) ? LEN_HI : ZERO;
                    end
                end
                LEN_HI: begin
                    if (advance) begin
                        word_q  <= len_bits[127:64];
                        state_q <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    // idx 15 means the low length word is already in the register
                    if (idx_q == 4'd15) begin
                        if (xfer) begin
                            valid_q    <= 1'b0;
                            complete_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end else if (advance) begin
                        word_q <= len_bits[63:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = in_phase && advance;
    assign bus.new_msg        = new_msg_q;
    assign bus.msg_word       = word_q;
    assign bus.msg_word_valid = valid_q;
    assign bus.msg_complete   = complete_q;

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Self-checking bench for sha512_msg_padder: table of messages plus random
// messages, compared against a byte-level FIPS 180-4 padding model.
module tb_sha512_msg_padder;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] word_q_t[$];

    typedef struct {
        int          nbytes;
        bit          rnd;
        int          ack_pct;
        int          vld_pct;
        int          stall_a;
        int          stall_b;
        int          in_stall;
        int          exp_words;
        logic [63:0] exp_lenlo;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sha512_msg_padder_if ifc();

    sha512_msg_padder #(.LEN_W(64)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // NIST two-block pattern "abcdefghbcdefghi..." or random bytes
    function automatic byte_q_t make_msg(input int n, input bit rnd);
        byte_q_t m;
        for (int i = 0; i < n; i++) begin
            m.push_back(rnd ? 8'($urandom) : 8'(8'h61 + (i / 8) + (i % 8)));
        end
        return m;
    endfunction

    function automatic word_q_t model(input byte_q_t msg);
        byte_q_t      p;
        word_q_t      w;
        logic [127:0] len;
        p   = msg;
        len = 128'(msg.size()) * 128'd8;
        p.push_back(8'h80);
        while ((p.size() % 128) != 112) p.push_back(8'h00);
        for (int i = 15; i >= 0; i--) p.push_back(len[8*i +: 8]);
        for (int i = 0; i < p.size(); i += 8) begin
            w.push_back({p[i], p[i+1], p[i+2], p[i+3], p[i+4], p[i+5], p[i+6], p[i+7]});
        end
        return w;
    endfunction

    task automatic run_msg(input string tag, input vec_t v, input byte_q_t msg);
        word_q_t     words;
        word_q_t     exp;
        logic [2:0]  lastb;
        logic [63:0] w;
        logic [63:0] prev_word;
        int nw, wi, oi, cyc, newc, idle_in, bubbles, ack_hold, gap_left;
        bit started, done, sa_done, sb_done, prev_stall, drive_v, ack;

        nw = (msg.size() + 7) / 8;
        exp = model(msg);
        lastb = 3'(msg.size() % 8);
        wi = 0; oi = 0; cyc = 0; newc = 0; idle_in = 0; bubbles = 0;
        ack_hold = 0; gap_left = 2;
        started = 0; done = 0; sa_done = 0; sb_done = 0; prev_stall = 0;
        prev_word = '0;
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) begin
                if (i * 8 + b < msg.size()) w[63-8*b -: 8] = msg[i*8+b];
            end
            words.push_back(w);
        end

        while (!done && cyc < 3000) begin
            drive_v = 0;
            if (wi < nw) begin
                if (wi == v.in_stall && gap_left > 0) gap_left--;
                else drive_v = (wi == 0) || (int'($urandom % 100) < v.vld_pct);
                if (wi > 0 && !drive_v) idle_in++;
            end
            ifc.in_valid = drive_v;
            ifc.in_data  = (wi < nw) ? words[wi] : {$urandom, $urandom};
            ifc.in_last  = (wi == nw - 1);
            ifc.in_bytes = (wi == nw - 1) ? lastb : 3'($urandom);
            if (!sa_done && oi == v.stall_a) begin sa_done = 1; ack_hold = 3; end
            if (!sb_done && oi == v.stall_b) begin sb_done = 1; ack_hold = 3; end
            if (ack_hold > 0) begin
                ack = 0;
                ack_hold--;
            end else begin
                ack = int'($urandom % 100) < v.ack_pct;
            end
            ifc.msg_word_ack = ack;
            #1;
            if (started && ifc.msg_complete) begin
                done = 1;
            end else begin
                if (prev_stall) begin
                    check({tag, " hold_word"}, ifc.msg_word, prev_word);
                    check({tag, " hold_valid"}, 64'(ifc.msg_word_valid), 64'd1);
                end
                if (ifc.msg_word_valid && !ack) check({tag, " ready_low"}, 64'(ifc.in_ready), 64'd0);
                if (ifc.msg_word_valid && !started) begin
                    started = 1;
                    check({tag, " new_msg"}, 64'(ifc.new_msg), 64'd1);
                    check({tag, " complete_drop"}, 64'(ifc.msg_complete), 64'd0);
                end
                newc += int'(ifc.new_msg);
                if (started && !ifc.msg_word_valid) bubbles++;
                if (ifc.msg_word_valid && ack) begin
                    if (oi < exp.size()) check($sformatf("%s word%0d", tag, oi), ifc.msg_word, exp[oi]);
                    if (oi == v.exp_words - 1) check({tag, " len_lo"}, ifc.msg_word, v.exp_lenlo);
                    oi++;
                end
                if (drive_v && ifc.in_ready) wi++;
                prev_stall = ifc.msg_word_valid && !ack;
                prev_word  = ifc.msg_word;
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " complete"}, 64'(done), 64'd1);
        check({tag, " word_count"}, 64'(oi), 64'(v.exp_words));
        check({tag, " valid_after"}, 64'(ifc.msg_word_valid), 64'd0);
        check({tag, " ready_after"}, 64'(ifc.in_ready), 64'd1);
        check({tag, " new_msg_count"}, 64'(newc), 64'd1);
        if (v.ack_pct == 100 && v.stall_a < 0 && v.stall_b < 0) begin
            check({tag, " bubbles"}, 64'(bubbles), 64'(idle_in));
        end
    endtask

    vec_t        vecs[12];
    vec_t        rv;
    byte_q_t     m;
    logic [63:0] rw[$];
    int          n;

    initial begin
        vecs[0]  = '{3,   1'b0, 100, 100, -1, -1, -1, 16, 64'h18};
        vecs[1]  = '{112, 1'b0, 100, 100, -1, -1, -1, 32, 64'h380};
        vecs[2]  = '{111, 1'b0, 100, 100, -1, -1, -1, 16, 64'h378};
        vecs[3]  = '{112, 1'b0, 100, 100,  5, 20, -1, 32, 64'h380};
        vecs[4]  = '{40,  1'b1, 100, 100, -1, -1,  2, 16, 64'h140};
        vecs[5]  = '{8,   1'b1, 100, 100, -1, -1, -1, 16, 64'h40};
        vecs[6]  = '{104, 1'b1, 100, 100, -1, -1, -1, 16, 64'h340};
        vecs[7]  = '{105, 1'b1, 100, 100, -1, -1, -1, 16, 64'h348};
        vecs[8]  = '{119, 1'b1, 100, 100, -1, -1, -1, 32, 64'h3b8};
        vecs[9]  = '{120, 1'b1, 100, 100, -1, -1, -1, 32, 64'h3c0};
        vecs[10] = '{128, 1'b1, 100, 100, -1, -1, -1, 32, 64'h400};
        vecs[11] = '{300, 1'b1,  70,  70, -1, -1, -1, 48, 64'h960};

        ifc.in_valid = 0; ifc.in_data = '0; ifc.in_last = 0; ifc.in_bytes = '0;
        ifc.msg_word_ack = 0;
        #2 reset_n = 0;
        #1;
        check("rst in_ready", 64'(ifc.in_ready), 64'd1);
        check("rst new_msg", 64'(ifc.new_msg), 64'd0);
        check("rst msg_word", ifc.msg_word, 64'd0);
        check("rst valid", 64'(ifc.msg_word_valid), 64'd0);
        check("rst complete", 64'(ifc.msg_complete), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Table messages run back to back: each starts while msg_complete is high
        for (int t = 0; t < 12; t++) begin
            run_msg($sformatf("vec%0d", t), vecs[t], make_msg(vecs[t].nbytes, vecs[t].rnd));
        end

        // Reset while word 5 of a 112-byte message is being presented
        m = make_msg(112, 0);
        rw.delete();
        for (int i = 0; i < 14; i++) begin
            rw.push_back({m[8*i], m[8*i+1], m[8*i+2], m[8*i+3], m[8*i+4], m[8*i+5], m[8*i+6], m[8*i+7]});
        end
        @(negedge clk);
        ifc.msg_word_ack = 1; ifc.in_last = 0; ifc.in_bytes = '0;
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1;
            ifc.in_data  = rw[i];
            @(negedge clk);
        end
        ifc.in_data = rw[5];
        #1;
        check("mid valid", 64'(ifc.msg_word_valid), 64'd1);
        check("mid word4", ifc.msg_word, rw[4]);
        #1 reset_n = 0;
        #1;
        check("arst in_ready", 64'(ifc.in_ready), 64'd1);
        check("arst new_msg", 64'(ifc.new_msg), 64'd0);
        check("arst msg_word", ifc.msg_word, 64'd0);
        check("arst valid", 64'(ifc.msg_word_valid), 64'd0);
        check("arst complete", 64'(ifc.msg_complete), 64'd0);
        ifc.in_valid = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        check("post_rst complete", 64'(ifc.msg_complete), 64'd0);
        check("post_rst valid", 64'(ifc.msg_word_valid), 64'd0);
        run_msg("abc_after_rst", vecs[0], make_msg(3, 0));

        for (int r = 0; r < 16; r++) begin
            n = 1 + int'($urandom % 300);
            rv = '{n, 1'b1, 50 + int'($urandom % 51), 50 + int'($urandom % 51), -1, -1, -1,
                   16 * ((n + 17 + 127) / 128), 64'(n) * 64'd8};
            run_msg($sformatf("rnd%0d", r), rv, make_msg(n, 1'b1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
